// File: rtl/piezo_tone_if.sv
// Control and status bundle for the piezo tone generator.
// The master issues note requests; the slave (the generator) drives the piezo outputs.
interface piezo_tone_if #(
  parameter int PER_W = 15,
  parameter int DUR_W = 8
) ();
  logic             clr;
  logic             start;
  logic [PER_W-1:0] note_per;
  logic [DUR_W-1:0] dur;
  logic             mode;
  logic             piezo;
  logic             piezo_n;
  logic             busy;
  logic             done;

  modport master (
    output clr, start, note_per, dur, mode,
    input  piezo, piezo_n, busy, done
  );

  modport slave (
    input  clr, start, note_per, dur, mode,
    output piezo, piezo_n, busy, done
  );
endinterface

// File: rtl/piezo_tone_gen.sv
// Plays one note on a piezo: a square wave of (note_per+1) cycles, repeated dur times.
// Two waveforms are available: the counter MSB, or a 50% duty pulse derived from the period.
module piezo_tone_gen #(
  parameter int PER_W = 15,
  parameter int DUR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  piezo_tone_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PER_W-1:0] freq_cnt_q, freq_cnt_d;
  logic [PER_W-1:0] per_lat_q, per_lat_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic             piezo_q, piezo_d;
  logic             done_q, done_d;

  logic start_ok;
  logic wrap;
  logic last_wrap;

  assign start_ok  = bus.start && !bus.clr && (state_q == IDLE);
  assign wrap      = (state_q == PLAY) && (freq_cnt_q == per_lat_q);
  assign last_wrap = wrap && (rem_q == DUR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      freq_cnt_q <= '0;
      per_lat_q  <= '0;
      rem_q      <= '0;
      mode_q     <= 1'b0;
      piezo_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_cnt_q <= freq_cnt_d;
      per_lat_q  <= per_lat_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      piezo_q    <= piezo_d;
      done_q     <= done_d;
    end
  end

  // clr has priority over both a new request and the completion of a note.
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.start && (bus.dur != '0)) state_d = PLAY;
        PLAY:    if (last_wrap) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    freq_cnt_d = freq_cnt_q;
    per_lat_d  = per_lat_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    done_d     = 1'b0;
    if (bus.clr) begin
      freq_cnt_d = '0;
      rem_d      = '0;
    end else if (start_ok) begin
      if (bus.dur == '0) begin
        done_d = 1'b1;
      end else begin
        per_lat_d  = bus.note_per;
        mode_d     = bus.mode;
        rem_d      = bus.dur;
        freq_cnt_d = '0;
      end
    end else if (state_q == PLAY) begin
      if (wrap) begin
        freq_cnt_d = '0;
        rem_d      = rem_q - DUR_W'(1);
        done_d     = last_wrap;
      end else begin
        freq_cnt_d = freq_cnt_q + PER_W'(1);
      end
    end
  end

  // The piezo level is computed from next-state values so the flop output lines up with the counter.
  always_comb begin
    piezo_d = 1'b0;
    if (state_d == PLAY) begin
      if (mode_d) piezo_d = (freq_cnt_d <= (per_lat_d >> 1));
      else        piezo_d = freq_cnt_d[PER_W-1];
    end
  end

  assign bus.piezo   = piezo_q;
  assign bus.piezo_n = ~piezo_q;
  assign bus.busy    = (state_q == PLAY);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Directed bench for piezo_tone_gen; each task drives one scenario and checks
// the packed outputs {busy, done, piezo, piezo_n} against hand-computed values.
module tb_piezo_tone_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  piezo_tone_if #(.PER_W(15), .DUR_W(8)) bus ();

  piezo_tone_gen #(.PER_W(15), .DUR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic test_reset();
    logic [3:0] obs;
    rst_n = 1'b0;
    bus.clr = 1'b0; bus.start = 1'b0; bus.note_per = '0; bus.dur = '0; bus.mode = 1'b0;
    #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0001) begin failures++; $display("[TB] FAIL reset_async got %b exp 0001", obs); end
    repeat (2) @(posedge clk);
    #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0001) begin failures++; $display("[TB] FAIL reset_held got %b exp 0001", obs); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0001) begin failures++; $display("[TB] FAIL reset_release got %b exp 0001", obs); end
  endtask

  task automatic test_basic_note();
    logic [7:0] pat;
    logic [3:0] obs, exp;
    pat = 8'b00110011;
    bus.note_per = 15'd3; bus.dur = 8'd2; bus.mode = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
      exp = {1'b1, 1'b0, pat[i], ~pat[i]};
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL basic_note cycle %0d got %b exp %b", i + 1, obs, exp); end
      @(posedge clk); #1;
    end
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0101) begin failures++; $display("[TB] FAIL basic_done got %b exp 0101", obs); end
    @(posedge clk); #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0001) begin failures++; $display("[TB] FAIL basic_after_done got %b exp 0001", obs); end
  endtask

  task automatic test_zero_dur();
    logic [3:0] obs;
    bus.note_per = 15'd5; bus.dur = 8'd0; bus.mode = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0101) begin failures++; $display("[TB] FAIL zero_dur_done got %b exp 0101", obs); end
    @(posedge clk); #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0001) begin failures++; $display("[TB] FAIL zero_dur_after got %b exp 0001", obs); end
  endtask

  task automatic test_per_zero();
    logic [3:0] obs;
    bus.note_per = 15'd0; bus.dur = 8'd3; bus.mode = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
      checks++;
      if (obs !== 4'b1010) begin failures++; $display("[TB] FAIL per_zero cycle %0d got %b exp 1010", i + 1, obs); end
      @(posedge clk); #1;
    end
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0101) begin failures++; $display("[TB] FAIL per_zero_done got %b exp 0101", obs); end
    @(posedge clk); #1;
  endtask

  task automatic test_clr();
    logic [3:0] obs;
    bus.note_per = 15'd9; bus.dur = 8'd3; bus.mode = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
      checks++;
      if (obs !== 4'b1010) begin failures++; $display("[TB] FAIL clr_play cycle %0d got %b exp 1010", i + 1, obs); end
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    bus.clr = 1'b1; bus.start = 1'b1; bus.note_per = 15'd2; bus.dur = 8'd1;
    @(posedge clk); #1;
    bus.clr = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
      checks++;
      if (obs !== 4'b0001) begin failures++; $display("[TB] FAIL clr_idle cycle %0d got %b exp 0001", i, obs); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat;
    logic [3:0] obs, exp;
    pat = 8'b00110011;
    bus.note_per = 15'd3; bus.dur = 8'd2; bus.mode = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
      exp = {1'b1, 1'b0, pat[i], ~pat[i]};
      checks++;
      if (obs !== exp) begin failures++; $display("[TB] FAIL b2b_note cycle %0d got %b exp %b", i + 1, obs, exp); end
      if (i == 1) begin
        bus.start = 1'b1; bus.note_per = 15'd7; bus.dur = 8'd5; bus.mode = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0101) begin failures++; $display("[TB] FAIL b2b_done got %b exp 0101", obs); end
    bus.start = 1'b1; bus.note_per = 15'd1; bus.dur = 8'd1; bus.mode = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b1010) begin failures++; $display("[TB] FAIL b2b_second_c1 got %b exp 1010", obs); end
    @(posedge clk); #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b1001) begin failures++; $display("[TB] FAIL b2b_second_c2 got %b exp 1001", obs); end
    @(posedge clk); #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0101) begin failures++; $display("[TB] FAIL b2b_second_done got %b exp 0101", obs); end
    @(posedge clk); #1;
  endtask

  task automatic test_long_note();
    logic [3:0] obs, exp;
    int         bad;
    int         first_bad;
    bus.note_per = 15'h7FFF; bus.dur = 8'd1; bus.mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 32768; i++) begin
      obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
      exp = (i >= 16384) ? 4'b1010 : 4'b1001;
      if (obs !== exp) begin
        bad++;
        if (first_bad < 0) first_bad = i + 1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 0) begin failures++; $display("[TB] FAIL long_note_wave bad cycles got %0d exp 0 (first at cycle %0d)", bad, first_bad); end
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0101) begin failures++; $display("[TB] FAIL long_note_done got %b exp 0101", obs); end
    @(posedge clk); #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0001) begin failures++; $display("[TB] FAIL long_note_after got %b exp 0001", obs); end
  endtask

  task automatic test_reset_mid_note();
    logic [3:0] obs;
    bus.note_per = 15'd3; bus.dur = 8'd2; bus.mode = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b1010) begin failures++; $display("[TB] FAIL rst_mid_pre got %b exp 1010", obs); end
    #3 rst_n = 1'b0;
    #1;
    obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
    checks++;
    if (obs !== 4'b0001) begin failures++; $display("[TB] FAIL rst_mid_async got %b exp 0001", obs); end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      obs = {bus.busy, bus.done, bus.piezo, bus.piezo_n};
      checks++;
      if (obs !== 4'b0001) begin failures++; $display("[TB] FAIL rst_mid_after cycle %0d got %b exp 0001", i, obs); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_note();
    test_zero_dur();
    test_per_zero();
    test_clr();
    test_back_to_back();
    test_long_note();
    test_reset_mid_note();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piezo_tone_gen.md
PIEZO_TONE_GEN -- requirements
Module: piezo_tone_gen

Interface
REQ-001 Parameter PER_W, default 15, width of note period and of the frequency counter.
REQ-002 Parameter DUR_W, default 8, width of note duration, counted in whole note periods.
REQ-003 Port clk  input  1  50 MHz system clock; all state on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port clr  input  1  synchronous abort; clears counters and returns to IDLE.
REQ-006 Port start  input  1  single-cycle request to play one note.
REQ-007 Port note_per  input  PER_W  note period minus one, in clk cycles; sampled on accepted start.
REQ-008 Port dur  input  DUR_W  number of note periods to play; sampled on accepted start.
REQ-009 Port mode  input  1  waveform select (0 = MSB, 1 = 50% duty); sampled on accepted start.
REQ-010 Port piezo  output  1  piezo drive.
REQ-011 Port piezo_n  output  1  complementary drive, always ~piezo.
REQ-012 Port busy  output  1  high while a note is playing.
REQ-013 Port done  output  1  one-cycle pulse on normal completion of a note.

Function
REQ-014 FSM states: IDLE, PLAY; busy SHALL be 1 exactly when state is PLAY.
REQ-015 Start is accepted only in IDLE with clr=0; start in PLAY SHALL be ignored without affecting the note in progress.
REQ-016 On accepted start with dur!=0: latch note_per, dur and mode; freq_cnt=0; rem=dur; next state PLAY.
REQ-017 On accepted start with dur==0: state stays IDLE; done pulses in the next cycle; piezo stays 0.
REQ-018 In PLAY, freq_cnt SHALL increment by 1 per cycle and wrap to 0 in the cycle after freq_cnt==per_lat (period = per_lat+1 cycles).
REQ-019 per_lat==0 SHALL give a wrap every cycle; per_lat==2^PER_W-1 SHALL wrap without overflow glitch.
REQ-020 On each wrap, rem SHALL decrement by 1; the wrap with rem==1 SHALL end the note: state goes to IDLE, freq_cnt goes to 0, done is 1 for that following cycle.
REQ-021 Mode 0: piezo = freq_cnt[PER_W-1] while in PLAY.
REQ-022 Mode 1: piezo = 1 while in PLAY and freq_cnt <= (per_lat >> 1), else 0; computed at PER_W bits with no truncation.
REQ-023 In IDLE, piezo SHALL be 0 and piezo_n SHALL be 1.
REQ-024 piezo SHALL be a register output (no combinational path from inputs).
REQ-025 clr=1 in any state: next cycle IDLE, freq_cnt=0, rem=0, done=0; clr SHALL win over simultaneous start or completion.
REQ-026 done and busy SHALL never be 1 in the same cycle.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, freq_cnt=0, rem=0, per_lat=0, mode latch=0, piezo=0, piezo_n=1, busy=0, done=0.
REQ-028 Reset deassertion SHALL take effect at the next clk edge, with no spurious done pulse.
REQ-029 Reset asserted mid-note SHALL abort the note with no done pulse.

Verification
REQ-030 PER_W=15, start with note_per=3, dur=2, mode=1 -> busy for 8 cycles; piezo pattern 1,1,0,0 twice; done pulses once on cycle 9.
REQ-031 note_per=0x7FFF, dur=1, mode=0 -> piezo low for 16384 cycles, then high for 16384; done after 32768 cycles.
REQ-032 start with dur=0 -> busy stays 0; piezo stays 0; done pulses once on the next cycle.
REQ-033 clr asserted in cycle 5 of a note with note_per=9, dur=3 -> IDLE next cycle, piezo=0, no done; start in the same cycle as clr is ignored.
REQ-034 Second start pulsed during PLAY with different note_per -> no effect on the period in progress; a start in the cycle after done is accepted.
REQ-035 rst_n pulsed low mid-note -> all outputs go to reset values asynchronously (piezo=0, piezo_n=1, busy=0, done=0); no done after release.
